control_sequencer: RTL and testbench
====================================

# control_sequencer

Microcoded control unit for the 4-bit computer. It steps through a fixed 5-state T-cycle (T0..T4) and decodes the instruction register opcode and ALU flags into the per-cycle control strobes. Those strobes include the program counter's en/OE/WE lines, so it is the initiator side of the counter's bus interface. It sits between the instruction register, the flags register and every bus participant: program counter, MAR, RAM, A, B, ALU, output register.

## Interface
Parameters:
- none (T-cycle length fixed at 5, opcode width fixed at 4)

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RESET_n  in  1  asynchronous, active-low reset
- run  in  1  1: advance one T-state per clock; 0: paused
- step  in  1  while run=0, a 0→1 transition advances exactly one T-state
- opcode  in  4  IR upper nibble, valid from T2 onward
- carry  in  1  registered carry flag
- zero  in  1  registered zero flag
- pc_en  out  1  increment program counter
- pc_oe  out  1  program counter drives bus
- pc_we  out  1  program counter loads from bus
- mar_we  out  1  MAR loads from bus
- ram_oe, ram_we  out  1  RAM drives bus / RAM writes bus
- ir_we, ir_oe  out  1  IR loads bus / IR drives its low nibble onto bus
- a_we, a_oe, b_we  out  1  A load / A drive / B load
- alu_oe, alu_sub, flag_we  out  1  ALU drives bus / subtract / flags latch
- out_we  out  1  output register loads bus
- halted  out  1  HLT executed
- tstate  out  3  current T-state, 0..4

## Operation
State:
- tstate register, 0..4; wraps 4→0.
- halted register.
- step_q: previous step sample, used for edge detection.

Advance condition:
- adv = !halted && (run || (step && !step_q)).
- step_q samples step every clock regardless of run.

Control decode:
- Combinational from tstate, opcode, carry, zero.
- All strobes not listed in a state are 0.
- Fetch, all opcodes:
  - T0: pc_oe, mar_we.
  - T1: ram_oe, ir_we, pc_en.
- Execute, T2..T4:
  - 0 NOP: none.
  - 1 LDA: T2 ir_oe+mar_we; T3 ram_oe+a_we.
  - 2 ADD: T2 ir_oe+mar_we; T3 ram_oe+b_we; T4 alu_oe+a_we+flag_we.
  - 3 SUB: as ADD, with alu_sub=1 in T3 and T4.
  - 4 STA: T2 ir_oe+mar_we; T3 a_oe+ram_we.
  - 5 LDI: T2 ir_oe+a_we.
  - 6 JMP: T2 ir_oe+pc_we.
  - 7 JC: T2 ir_oe+pc_we only if carry=1.
  - 8 JZ: T2 ir_oe+pc_we only if zero=1.
  - E OUT: T2 a_oe+out_we.
  - F HLT: at T2 with adv, set halted.
  - 9..D: treated as NOP.

Halt:
- halted=1 forces every strobe to 0 and freezes tstate.
- Only RESET_n clears halted.

Invariants:
- pc_en and pc_we are never both 1.
- At most one of pc_oe, ram_oe, ir_oe, a_oe, alu_oe is 1 in any state.

## Timing
- Reset (RESET_n low, asynchronous): tstate=0, halted=0, step_q=0.
- Strobes during and after reset reflect T0 decode: pc_oe=1, mar_we=1, all others 0, halted=0.
- Strobes are valid combinationally within the current T-state. Receivers act on the rising edge that ends that state.
- Instruction length is always 5 states; unused execute states are idle.
- Flags sampled in T2 are those latched by the previous instruction's T4.
- run=0 and no step edge: state and strobes hold indefinitely.
- Step held high advances exactly once.
- Step edge while run=1: no extra advance.
- Reset mid-instruction: immediate return to T0; the partial instruction is abandoned.
- HLT: halted rises on the edge ending T2. tstate remains 2, and strobes read 0 from the next cycle.
- Opcode changing outside T1 capture does not affect fetch states T0/T1.

## Test plan
- Reset then run=1 with opcode=0: tstate cycles 0,1,2,3,4,0. pc_oe+mar_we in T0, ram_oe+ir_we+pc_en in T1, no strobes in T2..T4.
- opcode=2 then opcode=3:
  - ADD: T2 ir_oe+mar_we, T3 ram_oe+b_we, T4 alu_oe+a_we+flag_we, alu_sub=0.
  - SUB: same strobes with alu_sub=1 in T3/T4.
- Conditional jumps:
  - opcode=7, carry=0: no pc_we in T2.
  - opcode=7, carry=1: ir_oe+pc_we in T2.
  - opcode=8 with zero=1/0: pc_we in T2 only when zero=1.
  - pc_en never 1 in the same state as pc_we.
- opcode=F at T2 with run=1: halted=1 after that edge, tstate stays 2, all strobes 0 for 20 clocks. Pulse RESET_n low mid-cycle: tstate=0, halted=0 immediately.
- run=0, step held high 10 clocks: tstate advances by exactly 1. Three separate step pulses advance by 3. No change with step low.
- Reset asserted asynchronously between clock edges in T3 of LDA: tstate=0 and strobes show T0 decode before the next CLK edge.

Source files
------------

// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Purpose  : Five-state T-cycle control unit decoding opcode and flags into
//            the per-cycle bus strobes of the 4-bit computer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer (
   input  logic       CLK,
   input  logic       RESET_n,
   input  logic       run,
   input  logic       step,
   input  logic [3:0] opcode,
   input  logic       carry,
   input  logic       zero,
   output logic       pc_en,
   output logic       pc_oe,
   output logic       pc_we,
   output logic       mar_we,
   output logic       ram_oe,
   output logic       ram_we,
   output logic       ir_we,
   output logic       ir_oe,
   output logic       a_we,
   output logic       a_oe,
   output logic       b_we,
   output logic       alu_oe,
   output logic       alu_sub,
   output logic       flag_we,
   output logic       out_we,
   output logic       halted,
   output logic [2:0] tstate
);

   localparam logic [2:0] c_T0 = 3'd0;
   localparam logic [2:0] c_T1 = 3'd1;
   localparam logic [2:0] c_T2 = 3'd2;
   localparam logic [2:0] c_T3 = 3'd3;
   localparam logic [2:0] c_T4 = 3'd4;

   localparam logic [3:0] c_OP_LDA = 4'h1;
   localparam logic [3:0] c_OP_ADD = 4'h2;
   localparam logic [3:0] c_OP_SUB = 4'h3;
   localparam logic [3:0] c_OP_STA = 4'h4;
   localparam logic [3:0] c_OP_LDI = 4'h5;
   localparam logic [3:0] c_OP_JMP = 4'h6;
   localparam logic [3:0] c_OP_JC  = 4'h7;
   localparam logic [3:0] c_OP_JZ  = 4'h8;
   localparam logic [3:0] c_OP_OUT = 4'hE;
   localparam logic [3:0] c_OP_HLT = 4'hF;

   logic [2:0] r_tstate;
   logic       r_halted;
   logic       r_step_q;
   logic [2:0] w_tstate_nxt;
   logic       w_halted_nxt;
   logic       w_adv;

   assign w_adv = !r_halted && (run || (step && !r_step_q));

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_tstate <= c_T0;
         r_halted <= 1'b0;
         r_step_q <= 1'b0;
      end else begin
         r_tstate <= w_tstate_nxt;
         r_halted <= w_halted_nxt;
         r_step_q <= step;
      end
   end

   // HLT latches halted instead of advancing, so tstate parks at T2
   always_comb begin
      w_tstate_nxt = r_tstate;
      w_halted_nxt = r_halted;
      if (w_adv) begin
         if (r_tstate == c_T2 && opcode == c_OP_HLT) begin
            w_halted_nxt = 1'b1;
         end else if (r_tstate == c_T4) begin
            w_tstate_nxt = c_T0;
         end else begin
            w_tstate_nxt = r_tstate + 3'd1;
         end
      end
   end

   always_comb begin
      pc_en   = 1'b0;
      pc_oe   = 1'b0;
      pc_we   = 1'b0;
      mar_we  = 1'b0;
      ram_oe  = 1'b0;
      ram_we  = 1'b0;
      ir_we   = 1'b0;
      ir_oe   = 1'b0;
      a_we    = 1'b0;
      a_oe    = 1'b0;
      b_we    = 1'b0;
      alu_oe  = 1'b0;
      alu_sub = 1'b0;
      flag_we = 1'b0;
      out_we  = 1'b0;
      if (!r_halted) begin
         case (r_tstate)
            c_T0: begin
               pc_oe  = 1'b1;
               mar_we = 1'b1;
            end
            c_T1: begin
               ram_oe = 1'b1;
               ir_we  = 1'b1;
               pc_en  = 1'b1;
            end
            c_T2: begin
               case (opcode)
                  c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                     ir_oe  = 1'b1;
                     mar_we = 1'b1;
                  end
                  c_OP_LDI: begin
                     ir_oe = 1'b1;
                     a_we  = 1'b1;
                  end
                  c_OP_JMP: begin
                     ir_oe = 1'b1;
                     pc_we = 1'b1;
                  end
                  c_OP_JC: begin
                     ir_oe = carry;
                     pc_we = carry;
                  end
                  c_OP_JZ: begin
                     ir_oe = zero;
                     pc_we = zero;
                  end
                  c_OP_OUT: begin
                     a_oe   = 1'b1;
                     out_we = 1'b1;
                  end
                  default: ;
               endcase
            end
            c_T3: begin
               case (opcode)
                  c_OP_LDA: begin
                     ram_oe = 1'b1;
                     a_we   = 1'b1;
                  end
                  c_OP_ADD, c_OP_SUB: begin
                     ram_oe  = 1'b1;
                     b_we    = 1'b1;
                     alu_sub = (opcode == c_OP_SUB);
                  end
                  c_OP_STA: begin
                     a_oe   = 1'b1;
                     ram_we = 1'b1;
                  end
                  default: ;
               endcase
            end
            c_T4: begin
               if (opcode == c_OP_ADD || opcode == c_OP_SUB) begin
                  alu_oe  = 1'b1;
                  a_we    = 1'b1;
                  flag_we = 1'b1;
                  alu_sub = (opcode == c_OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign halted = r_halted;
   assign tstate = r_tstate;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Self-checking bench for control_sequencer: decode table, corner
//            sequences and randomized run/step traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

   localparam logic [14:0] M_PC_EN   = 15'h4000;
   localparam logic [14:0] M_PC_OE   = 15'h2000;
   localparam logic [14:0] M_PC_WE   = 15'h1000;
   localparam logic [14:0] M_MAR_WE  = 15'h0800;
   localparam logic [14:0] M_RAM_OE  = 15'h0400;
   localparam logic [14:0] M_RAM_WE  = 15'h0200;
   localparam logic [14:0] M_IR_WE   = 15'h0100;
   localparam logic [14:0] M_IR_OE   = 15'h0080;
   localparam logic [14:0] M_A_WE    = 15'h0040;
   localparam logic [14:0] M_A_OE    = 15'h0020;
   localparam logic [14:0] M_B_WE    = 15'h0010;
   localparam logic [14:0] M_ALU_OE  = 15'h0008;
   localparam logic [14:0] M_ALU_SUB = 15'h0004;
   localparam logic [14:0] M_FLAG_WE = 15'h0002;
   localparam logic [14:0] M_OUT_WE  = 15'h0001;
   localparam logic [14:0] M_FETCH0  = M_PC_OE | M_MAR_WE;
   localparam logic [14:0] M_FETCH1  = M_RAM_OE | M_IR_WE | M_PC_EN;

   logic       CLK = 1'b0;
   logic       RESET_n, run, step, carry, zero;
   logic [3:0] opcode;
   logic       pc_en, pc_oe, pc_we, mar_we, ram_oe, ram_we, ir_we, ir_oe;
   logic       a_we, a_oe, b_we, alu_oe, alu_sub, flag_we, out_we, halted;
   logic [2:0] tstate;
   logic [14:0] strobes;

   assign strobes = {pc_en, pc_oe, pc_we, mar_we, ram_oe, ram_we, ir_we, ir_oe,
                     a_we, a_oe, b_we, alu_oe, alu_sub, flag_we, out_we};

   control_sequencer dut (
      .CLK(CLK), .RESET_n(RESET_n), .run(run), .step(step), .opcode(opcode),
      .carry(carry), .zero(zero), .pc_en(pc_en), .pc_oe(pc_oe), .pc_we(pc_we),
      .mar_we(mar_we), .ram_oe(ram_oe), .ram_we(ram_we), .ir_we(ir_we),
      .ir_oe(ir_oe), .a_we(a_we), .a_oe(a_oe), .b_we(b_we), .alu_oe(alu_oe),
      .alu_sub(alu_sub), .flag_we(flag_we), .out_we(out_we), .halted(halted),
      .tstate(tstate)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   // Microprogram ROM of the model: ucode[opcode][tstate]
   logic [14:0] ucode [16][5];

   // Model state
   int   m_t;
   logic m_h;
   logic m_sq;

   typedef struct {
      logic [3:0]  op;
      int          t;
      logic        c;
      logic        z;
      logic [14:0] exp;
   } vec_t;

   vec_t vecs [26];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [14:0] model_strobes(int t, logic [3:0] op, logic c, logic z, logic h);
      logic [14:0] m;
      if (h) return '0;
      m = ucode[op][t];
      if (t == 2 && ((op == 4'h7 && !c) || (op == 4'h8 && !z))) m = '0;
      return m;
   endfunction

   task automatic model_reset();
      m_t  = 0;
      m_h  = 1'b0;
      m_sq = 1'b0;
   endtask

   // Advance the model across one rising edge using the inputs now applied
   task automatic model_clock();
      logic adv;
      adv = !m_h && (run || (step && !m_sq));
      m_sq = step;
      if (adv) begin
         if (m_t == 2 && opcode == 4'hF) m_h = 1'b1;
         else m_t = (m_t + 1) % 5;
      end
   endtask

   task automatic pulse_reset();
      RESET_n = 1'b0;
      #1;
      RESET_n = 1'b1;
   endtask

   // Called right after a falling edge: reset, then run t states and pause
   task automatic goto_state(input logic [3:0] op, input int t, input logic c, input logic z);
      step   = 1'b0;
      run    = 1'b0;
      opcode = op;
      carry  = c;
      zero   = z;
      pulse_reset();
      run = 1'b1;
      repeat (t) @(posedge CLK);
      #1;
      run = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      for (int o = 0; o < 16; o++)
         for (int s = 0; s < 5; s++) ucode[o][s] = '0;
      for (int o = 0; o < 16; o++) begin
         ucode[o][0] = M_FETCH0;
         ucode[o][1] = M_FETCH1;
      end
      ucode[1][2] = M_IR_OE | M_MAR_WE;  ucode[1][3] = M_RAM_OE | M_A_WE;
      ucode[2][2] = M_IR_OE | M_MAR_WE;  ucode[2][3] = M_RAM_OE | M_B_WE;
      ucode[2][4] = M_ALU_OE | M_A_WE | M_FLAG_WE;
      ucode[3][2] = ucode[2][2];
      ucode[3][3] = ucode[2][3] | M_ALU_SUB;
      ucode[3][4] = ucode[2][4] | M_ALU_SUB;
      ucode[4][2] = M_IR_OE | M_MAR_WE;  ucode[4][3] = M_A_OE | M_RAM_WE;
      ucode[5][2] = M_IR_OE | M_A_WE;
      ucode[6][2] = M_IR_OE | M_PC_WE;
      ucode[7][2] = M_IR_OE | M_PC_WE;
      ucode[8][2] = M_IR_OE | M_PC_WE;
      ucode[14][2] = M_A_OE | M_OUT_WE;

      vecs = '{
         '{4'h0, 0, 1'b0, 1'b0, M_FETCH0},
         '{4'h0, 1, 1'b0, 1'b0, M_FETCH1},
         '{4'h0, 2, 1'b1, 1'b1, 15'h0},
         '{4'h0, 3, 1'b0, 1'b0, 15'h0},
         '{4'h0, 4, 1'b0, 1'b0, 15'h0},
         '{4'h1, 2, 1'b0, 1'b0, M_IR_OE | M_MAR_WE},
         '{4'h1, 3, 1'b0, 1'b0, M_RAM_OE | M_A_WE},
         '{4'h1, 4, 1'b0, 1'b0, 15'h0},
         '{4'h2, 2, 1'b0, 1'b0, M_IR_OE | M_MAR_WE},
         '{4'h2, 3, 1'b0, 1'b0, M_RAM_OE | M_B_WE},
         '{4'h2, 4, 1'b1, 1'b0, M_ALU_OE | M_A_WE | M_FLAG_WE},
         '{4'h3, 3, 1'b0, 1'b0, M_RAM_OE | M_B_WE | M_ALU_SUB},
         '{4'h3, 4, 1'b0, 1'b0, M_ALU_OE | M_A_WE | M_FLAG_WE | M_ALU_SUB},
         '{4'h4, 2, 1'b0, 1'b0, M_IR_OE | M_MAR_WE},
         '{4'h4, 3, 1'b0, 1'b0, M_A_OE | M_RAM_WE},
         '{4'h5, 2, 1'b0, 1'b0, M_IR_OE | M_A_WE},
         '{4'h6, 2, 1'b0, 1'b0, M_IR_OE | M_PC_WE},
         '{4'h7, 2, 1'b0, 1'b1, 15'h0},
         '{4'h7, 2, 1'b1, 1'b0, M_IR_OE | M_PC_WE},
         '{4'h8, 2, 1'b0, 1'b1, M_IR_OE | M_PC_WE},
         '{4'h8, 2, 1'b1, 1'b0, 15'h0},
         '{4'hE, 2, 1'b0, 1'b0, M_A_OE | M_OUT_WE},
         '{4'h9, 2, 1'b1, 1'b1, 15'h0},
         '{4'hD, 3, 1'b0, 1'b0, 15'h0},
         '{4'hF, 1, 1'b0, 1'b0, M_FETCH1},
         '{4'hF, 2, 1'b0, 1'b0, 15'h0}
      };

      RESET_n = 1'b0; run = 1'b0; step = 1'b0;
      opcode = 4'h0; carry = 1'b0; zero = 1'b0;
      #1;
      check("reset_tstate", 32'(tstate), 32'd0);
      check("reset_halted", 32'(halted), 32'd0);
      check("reset_strobes", 32'(strobes), 32'(M_FETCH0));
      #1 RESET_n = 1'b1;
      @(negedge CLK);

      // Free run with NOP: tstate 0,1,2,3,4,0
      run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("nop_cycle", 32'(tstate), 32'(i % 5));
         @(negedge CLK);
      end
      run = 1'b0;

      // Decode table
      foreach (vecs[i]) begin
         goto_state(vecs[i].op, vecs[i].t, vecs[i].c, vecs[i].z);
         check($sformatf("vec%0d_tstate", i), 32'(tstate), 32'(vecs[i].t));
         check($sformatf("vec%0d_op%0h_t%0d", i, vecs[i].op, vecs[i].t),
               32'(strobes), 32'(vecs[i].exp));
      end

      // HLT: park at T2 with strobes off, then asynchronous reset recovers
      goto_state(4'hF, 2, 1'b0, 1'b0);
      run = 1'b1;
      @(posedge CLK);
      #1;
      check("hlt_halted", 32'(halted), 32'd1);
      check("hlt_tstate", 32'(tstate), 32'd2);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check("hlt_hold", {17'd0, tstate, halted, strobes}, {17'd0, 3'd2, 1'b1, 15'h0});
      end
      #2 RESET_n = 1'b0;
      #1;
      check("hlt_rst_tstate", 32'(tstate), 32'd0);
      check("hlt_rst_halted", 32'(halted), 32'd0);
      check("hlt_rst_strobes", 32'(strobes), 32'(M_FETCH0));
      RESET_n = 1'b1;
      run = 1'b0;
      @(negedge CLK);

      // Single-step behaviour
      goto_state(4'h0, 0, 1'b0, 1'b0);
      step = 1'b1;
      repeat (10) @(negedge CLK);
      check("step_held", 32'(tstate), 32'd1);
      step = 1'b0;
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         @(negedge CLK);
         step = 1'b0;
         @(negedge CLK);
      end
      check("step_pulses", 32'(tstate), 32'd4);
      repeat (5) @(negedge CLK);
      check("step_low_hold", 32'(tstate), 32'd4);

      // Asynchronous reset between edges during LDA T3
      goto_state(4'h1, 3, 1'b0, 1'b0);
      check("lda_t3", 32'(strobes), 32'(M_RAM_OE | M_A_WE));
      #2 RESET_n = 1'b0;
      #1;
      check("lda_rst_tstate", 32'(tstate), 32'd0);
      check("lda_rst_strobes", 32'(strobes), 32'(M_FETCH0));
      RESET_n = 1'b1;
      @(negedge CLK);

      // Randomized traffic against the model
      pulse_reset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         check("rnd_tstate", 32'(tstate), 32'(m_t));
         check("rnd_halted", 32'(halted), 32'(m_h));
         check("rnd_strobes", 32'(strobes),
               32'(model_strobes(m_t, opcode, carry, zero, m_h)));
         check("inv_pc", 32'(pc_en & pc_we), 32'd0);
         check("inv_bus", 32'($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) > 1), 32'd0);
         if ($urandom_range(0, 39) == 0) begin
            pulse_reset();
            model_reset();
         end
         run    = ($urandom_range(0, 2) == 0);
         step   = $urandom_range(0, 1) == 1;
         opcode = 4'($urandom_range(0, 15));
         if (opcode == 4'hF && $urandom_range(0, 3) != 0) opcode = 4'($urandom_range(0, 14));
         carry  = $urandom_range(0, 1) == 1;
         zero   = $urandom_range(0, 1) == 1;
         #1;
         check("rnd_comb", 32'(strobes), 32'(model_strobes(m_t, opcode, carry, zero, m_h)));
         model_clock();
         @(negedge CLK);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
